// File: rtl/video2ram_if.sv
// Line-buffer RAM write port: video2ram drives it as master, the RAM consumes it as slave.
interface video2ram_if;
    logic [14:0] wraddr;
    logic [23:0] wrdata;
    logic        wren;

    modport master (output wraddr, output wrdata, output wren);
    modport slave  (input  wraddr, input  wrdata, input  wren);
endinterface

// File: rtl/video2ram.sv
// Capture-side line-buffer writer: locks to the console frame rate, then writes the
// capture window into RAM as a circular buffer of whole lines and flags the reader start.
module video2ram #(
    parameter int H_CAPTURE_START    = 128,
    parameter int V_CAPTURE_START    = 36,
    parameter int BUFFER_LINE_LENGTH = 720,
    parameter int V_CAPTURE_LINES    = 480,
    parameter int RAM_NUMWORDS       = 23040,
    parameter int TRIGGER_LINE       = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] rgb_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    video2ram_if.master wr,
    output logic        starttrigger,
    output logic        frame_locked,
    output logic [11:0] line_count
);
    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        MEASURE = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [11:0] H_FIRST_C = 12'(H_CAPTURE_START);
    localparam logic [11:0] H_END_C   = 12'(H_CAPTURE_START + BUFFER_LINE_LENGTH);
    localparam logic [11:0] V_FIRST_C = 12'(V_CAPTURE_START);
    localparam logic [11:0] V_END_C   = 12'(V_CAPTURE_START + V_CAPTURE_LINES);
    localparam logic [11:0] TRIG_CY_C = 12'(V_CAPTURE_START + TRIGGER_LINE);
    localparam logic [15:0] H_FIRST_W = 16'(H_CAPTURE_START);
    localparam logic [15:0] STRIDE_W  = 16'(BUFFER_LINE_LENGTH);
    localparam logic [15:0] WRAP_W    = 16'(RAM_NUMWORDS - BUFFER_LINE_LENGTH);

    logic [23:0] rgb_q_r, rgb_d_r;
    logic        hs_q_r, hs_qq_r, vs_q_r, vs_qq_r;
    logic        vs_pending_r, hs_fall_d_r;
    logic [11:0] cx_r, cy_r;
    logic [14:0] line_base_r;
    state_t      state_r, state_s;
    logic        locked_s;
    logic        hs_fall_s, vs_fall_s, frame_start_s;
    logic        h_win_s, v_win_s, write_s;
    logic [11:0] count_s, cx_inc_s, cy_inc_s;
    logic [15:0] next_base_s;
    logic [14:0] adv_base_s;

    // Sync edge detection, window decode and saturating/wrapping counter arithmetic.
    always_comb begin
        hs_fall_s     = hs_qq_r & ~hs_q_r;
        vs_fall_s     = vs_qq_r & ~vs_q_r;
        frame_start_s = hs_fall_s & (vs_pending_r | vs_fall_s);
        count_s       = cy_r + 12'd1;
        cx_inc_s      = (cx_r == 12'hFFF) ? cx_r : cx_r + 12'd1;
        cy_inc_s      = (cy_r == 12'hFFF) ? cy_r : cy_r + 12'd1;
        h_win_s       = (cx_r >= H_FIRST_C) && (cx_r < H_END_C);
        v_win_s       = (cy_r >= V_FIRST_C) && (cy_r < V_END_C);
        write_s       = (state_r == CAPTURE) && h_win_s && v_win_s;
        next_base_s   = {1'b0, line_base_r} + STRIDE_W;
        if (next_base_s > WRAP_W) begin
            adv_base_s = 15'd0;
        end else begin
            adv_base_s = next_base_s[14:0];
        end
    end

    // Lock state machine: next state and frame_locked, evaluated on frame-start only.
    always_comb begin
        state_s  = state_r;
        locked_s = frame_locked;
        if (frame_start_s) begin
            case (state_r)
                WAIT_VS: state_s = MEASURE;
                MEASURE: begin
                    if (count_s == line_count) begin
                        state_s  = CAPTURE;
                        locked_s = 1'b1;
                    end else begin
                        state_s  = MEASURE;
                    end
                end
                CAPTURE: begin
                    if (count_s != line_count) begin
                        state_s  = MEASURE;
                        locked_s = 1'b0;
                    end else begin
                        state_s  = CAPTURE;
                    end
                end
                default: begin
                    state_s  = WAIT_VS;
                    locked_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Stage 1: input registers, pixel/line counters, line base and frame measurement.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rgb_q_r      <= 24'd0;
            rgb_d_r      <= 24'd0;
            hs_q_r       <= 1'b1;
            hs_qq_r      <= 1'b1;
            vs_q_r       <= 1'b1;
            vs_qq_r      <= 1'b1;
            hs_fall_d_r  <= 1'b0;
            vs_pending_r <= 1'b0;
            cx_r         <= 12'd0;
            cy_r         <= 12'd0;
            line_base_r  <= 15'd0;
            line_count   <= 12'd0;
            frame_locked <= 1'b0;
            state_r      <= WAIT_VS;
        end else begin
            rgb_q_r      <= rgb_in;
            rgb_d_r      <= rgb_q_r;
            hs_q_r       <= hsync_in;
            hs_qq_r      <= hs_q_r;
            vs_q_r       <= vsync_in;
            vs_qq_r      <= vs_q_r;
            hs_fall_d_r  <= hs_fall_s;
            cx_r         <= hs_fall_s ? 12'd0 : cx_inc_s;
            frame_locked <= locked_s;
            state_r      <= state_s;
            if (frame_start_s) begin
                cy_r         <= 12'd0;
                line_base_r  <= 15'd0;
                vs_pending_r <= 1'b0;
                line_count   <= count_s;
            end else begin
                // cy_r still names the line that is ending, so it decides the advance.
                if (hs_fall_s) begin
                    cy_r <= cy_inc_s;
                    if (v_win_s) begin
                        line_base_r <= adv_base_s;
                    end
                end
                if (vs_fall_s) begin
                    vs_pending_r <= 1'b1;
                end
            end
        end
    end

    // Stage 2: registered RAM write port and sticky reader start flag.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr.wren      <= 1'b0;
            wr.wraddr    <= 15'd0;
            wr.wrdata    <= 24'd0;
            starttrigger <= 1'b0;
        end else begin
            wr.wren <= write_s;
            if (write_s) begin
                wr.wraddr <= 15'({1'b0, line_base_r} + {4'b0000, cx_r} - H_FIRST_W);
                wr.wrdata <= rgb_d_r;
            end
            if (hs_fall_d_r && (state_r == CAPTURE) && (cy_r == TRIG_CY_C)) begin
                starttrigger <= 1'b1;
            end
        end
    end
endmodule
